// File: rtl/mux_rr_nx1.sv
// N-to-1 channel mux with a one-entry registered output; fixed-select or round-robin grant.
// Optional transfer counter output enabled by defining MUX_RR_NX1_XFER_CNT_EN.
module mux_rr_nx1 #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SEL_W-1:0]     out_ch
`ifdef MUX_RR_NX1_XFER_CNT_EN
    ,
    output logic [15:0]          xfer_cnt
`endif
);

    logic             load_en_s;
    logic             grant_vld_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic [SEL_W-1:0] cand_s;
    logic [SEL_W-1:0] ptr_r;
    logic             xfer_s;

    assign load_en_s = !out_valid || out_ready;
    assign xfer_s    = |in_ready;

    // Grant selection: fixed sel, or the first valid channel after ptr (wrapping, ptr last).
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = '0;
        cand_s      = '0;
        if (mode == 1'b0) begin
            if ((32'(sel) < 32'(N)) && in_valid[sel]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = sel;
            end else begin
                grant_vld_s = 1'b0;
            end
        end else begin
            // Walk farthest-first so the nearest valid channel after ptr overwrites last.
            for (int k = N; k >= 1; k--) begin
                cand_s = SEL_W'((32'(ptr_r) + 32'(k)) % 32'(N));
                if (in_valid[cand_s]) begin
                    grant_vld_s = 1'b1;
                    grant_idx_s = cand_s;
                end else begin
                    grant_vld_s = grant_vld_s;
                end
            end
        end
    end

    // One-hot ready toward the granted channel, only when the output register can load.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (rst_n && load_en_s && grant_vld_s && (grant_idx_s == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end else begin
                in_ready[i] = 1'b0;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_r     <= SEL_W'(N - 1);
        end else if (xfer_s) begin
            out_data  <= in_data[grant_idx_s*WIDTH +: WIDTH];
            out_ch    <= grant_idx_s;
            out_valid <= 1'b1;
            if (mode) begin
                ptr_r <= grant_idx_s;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_NX1_XFER_CNT_EN
    // Count completed output handshakes; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_cnt <= 16'd0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Scoreboard bench for mux_rr_nx1 (WIDTH=4, N=4): driver predicts grants and queues words,
// a monitor compares the presented output against the queue head.
module tb_mux_rr_nx1;
    localparam int WIDTH = 4;
    localparam int N     = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] in_data = 16'h0000;
    logic [3:0]  in_valid = 4'h0;
    logic [3:0]  in_ready;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_ch;
`ifdef MUX_RR_NX1_XFER_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    mux_rr_nx1 #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch)
`ifdef MUX_RR_NX1_XFER_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [5:0] exp_q[$];
    bit   m_occ = 1'b0;
    int   m_ptr = N - 1;
    bit   model_live = 1'b0;
    bit   just_reset = 1'b0;
    int   hs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Which channel the rules say is granted this cycle, -1 if none.
    function automatic int model_grant(input logic m, input logic [1:0] s, input logic [3:0] v);
        if (!m) return (v[s] == 1'b1) ? int'(s) : -1;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_cycle(input logic m, input logic [1:0] s, input logic [3:0] v,
                               input logic [15:0] d, input logic ordy, input logic r);
        int g;
        bit load;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst_n = r; mode = m; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        g = model_grant(m, s, v);
        load = r && (!m_occ || ordy) && (g >= 0);
        exp_rdy = load ? (4'b0001 << g) : 4'b0000;
        if (model_live) begin
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(m_occ));
            if (just_reset) begin
                check("rst_out_data", 32'(out_data), 32'd0);
                check("rst_out_ch", 32'(out_ch), 32'd0);
            end
`ifdef MUX_RR_NX1_XFER_CNT_EN
            check("xfer_cnt", 32'(xfer_cnt), 32'(hs % 65536));
`endif
        end
        #2;
        if (!r) begin
            exp_q.delete();
            m_occ = 1'b0; m_ptr = N - 1; model_live = 1'b1; just_reset = 1'b1; hs = 0;
        end else begin
            just_reset = 1'b0;
            if (load) begin
                exp_q.push_back({d[g*WIDTH +: WIDTH], 2'(g)});
                m_occ = 1'b1;
                if (m) m_ptr = g;
            end else if (m_occ && ordy) begin
                m_occ = 1'b0;
            end
        end
    endtask

    // Monitor: whenever a word is presented it must match the queue head; pop on handshake.
    always @(negedge clk) begin
        #2;
        if (model_live && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(out_valid), 32'd0);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0][5:2]));
                check("out_ch", 32'(out_ch), 32'(exp_q[0][1:0]));
            end
            if (out_ready === 1'b1) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                hs++;
            end
        end
    end

    initial begin
        // Reset and directed single-channel fixed select.
        drive_cycle(1'b0, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b0);
        drive_cycle(1'b0, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b0);
        drive_cycle(1'b0, 2'd1, 4'b0010, 16'h00A0, 1'b1, 1'b1);
        drive_cycle(1'b0, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b1);
        // Round-robin over all channels with data 1,2,3,4.
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 2'd0, 4'hF, 16'h4321, 1'b1, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h4321, 1'b1, 1'b1);
        // Load 5 then stall three cycles, then release.
        drive_cycle(1'b0, 2'd2, 4'b0100, 16'h0500, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'd0, 4'hF, 16'h9876, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'hF, 16'h9876, 1'b1, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b1);
        // Fixed select on an idle channel, then round-robin with the same inputs.
        drive_cycle(1'b0, 2'd3, 4'b0001, 16'h0007, 1'b1, 1'b1);
        drive_cycle(1'b1, 2'd3, 4'b0001, 16'h0007, 1'b1, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b1);
        // Reset while holding a word, then first round-robin grant.
        drive_cycle(1'b1, 2'd0, 4'b0100, 16'h0B00, 1'b0, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h0000, 1'b0, 1'b0);
        drive_cycle(1'b1, 2'd0, 4'hF, 16'hCDEF, 1'b1, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b1);
        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle(1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom),
                        ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) != 0));
        end
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef MUX_RR_NX1_XFER_CNT_EN
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h0000, 1'b1, 1'b0);
        while (hs < 65537) drive_cycle(1'b1, 2'd0, 4'hF, 16'($urandom), 1'b1, 1'b1);
        drive_cycle(1'b1, 2'd0, 4'h0, 16'h0000, 1'b0, 1'b1);
        check("xfer_cnt_wrap", 32'(xfer_cnt), 32'd1);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_rr_nx1.md
MUX_RR_NX1 -- requirements
Module: mux_rr_nx1

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width per channel (>=1).
REQ-002 SHALL have parameter N, default 4, input channel count (>=2).
REQ-003 SHALL define derived SEL_W = $clog2(N) (N=4 -> 2).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 mode  input  1  0 = fixed select via sel; 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel select, used only when mode=0.
REQ-008 in_data  input  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  N  per-channel valid.
REQ-010 in_ready  output  N  per-channel ready; combinational.
REQ-011 out_data  output  WIDTH  registered output data.
REQ-012 out_valid  output  1  registered output valid.
REQ-013 out_ready  input  1  downstream ready.
REQ-014 out_ch  output  SEL_W  registered index of the channel that supplied out_data.

Function
REQ-015 load_en = !out_valid || out_ready; one-entry output register, no skid buffer.
REQ-016 Mode 0: grant = sel when sel < N and in_valid[sel]=1; sel >= N -> no grant, all in_ready=0.
REQ-017 Mode 1: grant = first channel with in_valid=1, searching ptr+1, ptr+2, ... wrapping modulo N, ending at ptr.
REQ-018 in_ready[i] SHALL be 1 only for the granted channel and only when load_en=1; at most one bit set.
REQ-019 Transfer on in_valid[g] && in_ready[g]: next edge out_data <= channel g data, out_ch <= g, out_valid <= 1; latency 1 cycle.
REQ-020 Output handshake only (out_valid && out_ready, no transfer): next edge out_valid <= 0; out_data and out_ch hold.
REQ-021 Output and input handshake in the same cycle: register reloads; out_valid stays 1, full throughput.
REQ-022 out_valid=1 and out_ready=0: out_data, out_ch and out_valid hold; all in_ready=0.
REQ-023 Round-robin pointer ptr SHALL update to g only on a mode-1 transfer; mode-0 transfers leave ptr unchanged.
REQ-024 A change of mode or sel SHALL affect only the next grant, never the contents of the output register.
REQ-025 No valid input, or no grant: no load; output register follows REQ-020/022.

Reset
REQ-026 rst_n=0 at an edge: out_valid=0, out_data=0, out_ch=0, ptr=N-1 (channel 0 has first mode-1 priority).
REQ-027 in_ready SHALL be 0 while rst_n=0; reset mid-transfer discards the held word.

Configuration
REQ-028 Macro MUX_RR_NX1_XFER_CNT_EN defined: add output xfer_cnt, 16 bits, +1 per output handshake, wraps 65535 -> 0, reset to 0.
REQ-029 Macro not defined: no xfer_cnt port and no counter logic; all other behaviour identical.

Verification (WIDTH=4, N=4)
REQ-030 Reset, then mode=0, sel=1, in_valid=4'b0010, ch1=4'hA, out_ready=1 -> in_ready=4'b0010; next cycle out_valid=1, out_data=A, out_ch=1.
REQ-031 Mode=1, all in_valid=1, channel data 1,2,3,4, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles, out_data 1,2,3,4,1.
REQ-032 Output holds 4'h5, out_ready=0 for 3 cycles -> out_data=5 and out_valid=1 stable; in_ready=0; after out_ready=1 one cycle later the next word loads.
REQ-033 Mode=0, sel=3, in_valid[3]=0, in_valid[0]=1 -> in_ready=0, no load; mode=1 and same inputs -> channel 0 granted.
REQ-034 rst_n=0 for one edge while out_valid=1 -> out_valid=0, out_data=0; first mode-1 grant after reset is channel 0.
REQ-035 With MUX_RR_NX1_XFER_CNT_EN: 65537 output handshakes -> xfer_cnt=1; without the macro, bench compiles without xfer_cnt.
